// File: rtl/simple_calc_arbiter.sv
// Round-robin front end that time-shares one combinational simple_calc between
// requesters A and B: latch operands, hold them for a settle window, capture, ack.
module simple_calc_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic [3:0] X_A,
    input  logic [3:0] Y_A,
    input  logic [3:0] X_B,
    input  logic [3:0] Y_B,
    input  logic [1:0] OP_A,
    input  logic [1:0] OP_B,
    output logic [3:0] CALC_X,
    output logic [3:0] CALC_Y,
    output logic [1:0] CALC_OP,
    input  logic [7:0] CALC_RESULT,
    input  logic       CALC_CARRY,
    input  logic       CALC_OVERFLOW,
    output logic       ACK_A,
    output logic       ACK_B,
    output logic [7:0] RSP_RESULT,
    output logic       RSP_CARRY,
    output logic       RSP_OVERFLOW,
    output logic       BUSY,
    output logic       GRANT_ID,
    output logic [7:0] OP_COUNT
);

    // The settle counter is loaded with SETTLE_CYCLES-1 so capture lands
    // exactly SETTLE_CYCLES edges after acceptance.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       prio_reg, prio_next;
    logic [3:0] calc_x_reg, calc_x_next;
    logic [3:0] calc_y_reg, calc_y_next;
    logic [1:0] calc_op_reg, calc_op_next;
    logic       ack_a_reg, ack_a_next;
    logic       ack_b_reg, ack_b_next;
    logic [7:0] rsp_result_reg, rsp_result_next;
    logic       rsp_carry_reg, rsp_carry_next;
    logic       rsp_overflow_reg, rsp_overflow_next;
    logic       busy_reg, busy_next;
    logic       grant_reg, grant_next;
    logic [7:0] op_count_reg, op_count_next;
    logic       win;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            prio_reg         <= 1'b0;
            calc_x_reg       <= '0;
            calc_y_reg       <= '0;
            calc_op_reg      <= '0;
            ack_a_reg        <= 1'b0;
            ack_b_reg        <= 1'b0;
            rsp_result_reg   <= '0;
            rsp_carry_reg    <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            busy_reg         <= 1'b0;
            grant_reg        <= 1'b0;
            op_count_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            prio_reg         <= prio_next;
            calc_x_reg       <= calc_x_next;
            calc_y_reg       <= calc_y_next;
            calc_op_reg      <= calc_op_next;
            ack_a_reg        <= ack_a_next;
            ack_b_reg        <= ack_b_next;
            rsp_result_reg   <= rsp_result_next;
            rsp_carry_reg    <= rsp_carry_next;
            rsp_overflow_reg <= rsp_overflow_next;
            busy_reg         <= busy_next;
            grant_reg        <= grant_next;
            op_count_reg     <= op_count_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        prio_next         = prio_reg;
        calc_x_next       = calc_x_reg;
        calc_y_next       = calc_y_reg;
        calc_op_next      = calc_op_reg;
        ack_a_next        = 1'b0;
        ack_b_next        = 1'b0;
        rsp_result_next   = rsp_result_reg;
        rsp_carry_next    = rsp_carry_reg;
        rsp_overflow_next = rsp_overflow_reg;
        busy_next         = busy_reg;
        grant_next        = grant_reg;
        op_count_next     = op_count_reg;
        win               = 1'b0;

        case (state_reg)
            IDLE: begin
                if (REQ_A || REQ_B) begin
                    // Tie goes to prio; a lone requester always wins.
                    win          = (REQ_A && REQ_B) ? prio_reg : REQ_B;
                    calc_x_next  = win ? X_B  : X_A;
                    calc_y_next  = win ? Y_B  : Y_A;
                    calc_op_next = win ? OP_B : OP_A;
                    grant_next   = win;
                    prio_next    = ~win;
                    busy_next    = 1'b1;
                    cnt_next     = CNT_LOAD;
                    state_next   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    rsp_result_next   = CALC_RESULT;
                    rsp_carry_next    = CALC_CARRY;
                    rsp_overflow_next = CALC_OVERFLOW;
                    ack_a_next        = ~grant_reg;
                    ack_b_next        = grant_reg;
                    op_count_next     = op_count_reg + 8'd1;
                    state_next        = DONE;
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign CALC_X       = calc_x_reg;
    assign CALC_Y       = calc_y_reg;
    assign CALC_OP      = calc_op_reg;
    assign ACK_A        = ack_a_reg;
    assign ACK_B        = ack_b_reg;
    assign RSP_RESULT   = rsp_result_reg;
    assign RSP_CARRY    = rsp_carry_reg;
    assign RSP_OVERFLOW = rsp_overflow_reg;
    assign BUSY         = busy_reg;
    assign GRANT_ID     = grant_reg;
    assign OP_COUNT     = op_count_reg;

endmodule
